instr_encoder: RTL and testbench

Instruction encoder and loader for the single-cycle MIPS processor. It is the producer-side counterpart of the control unit's opcode/funct decode. It accepts instruction fields (type, opcode, funct, registers, immediate or target), packs them into 32-bit MIPS words and writes them into consecutive instruction-memory locations. A 2-entry buffer decouples the field input from a memory port that may stall. It is used to preload programs before releasing the core.

---
 rtl/instr_encoder.sv | 140 ++++++++++++++
 tb/tb_instr_encoder.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words and streams them into
// consecutive instruction-memory locations through a 2-entry write buffer.
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic              In_Last,
    input  logic [1:0]        Type_In,
    input  logic [5:0]        OpCode_In,
    input  logic [5:0]        Funct_In,
    input  logic [4:0]        Rs_In,
    input  logic [4:0]        Rt_In,
    input  logic [4:0]        Rd_In,
    input  logic [4:0]        Shamt_In,
    input  logic [15:0]       Imm_In,
    input  logic [25:0]       Target_In,
    output logic              IMem_WrEn,
    input  logic              IMem_Ready,
    output logic [ADDR_W-1:0] IMem_Addr,
    output logic [31:0]       IMem_WrData,
    output logic              Busy,
    output logic              Done,
    output logic              Err_Type,
    output logic              Err_Ovf,
    output logic [1:0]        Dbg_State
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  acc_cnt;
    logic [ADDR_W-1:0] buf_addr [2];
    logic [31:0]       buf_data [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              err_type_q;
    logic              err_ovf_q;

    logic              accept;
    logic              is_rsvd;
    logic              push;
    logic              pop;
    logic [31:0]       enc_word;
    logic [ADDR_W-1:0] wr_addr;

    // Handshakes: a bundle moves on In_Valid && In_Ready, a word on
    // IMem_WrEn && IMem_Ready; both sampled at the rising edge of CLK.
    assign In_Ready    = (state == RUN) && (count < 2'd2) && (acc_cnt < CNT_W'(DEPTH));
    assign accept      = In_Valid && In_Ready;
    assign is_rsvd     = (Type_In == 2'b11);
    assign push        = accept && !is_rsvd;
    assign IMem_WrEn   = (count != 2'd0);
    assign pop         = IMem_WrEn && IMem_Ready;
    assign IMem_Addr   = buf_addr[rd_ptr];
    assign IMem_WrData = buf_data[rd_ptr];
    assign Busy        = (state == RUN) || (state == DRAIN);
    assign Done        = (state == DONE);
    assign Err_Type    = err_type_q;
    assign Err_Ovf     = err_ovf_q;
    assign Dbg_State   = state;

    // Address wraps naturally at 2^ADDR_W through the truncating add.
    assign wr_addr = base_q + ADDR_W'(acc_cnt);

    always_comb begin
        enc_word = '0;
        case (Type_In)
            2'b00:   enc_word = {6'b000000, Rs_In, Rt_In, Rd_In, Shamt_In, Funct_In};
            2'b01:   enc_word = {OpCode_In, Rs_In, Rt_In, Imm_In};
            2'b10:   enc_word = {OpCode_In, Target_In};
            default: enc_word = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            base_q      <= '0;
            acc_cnt     <= '0;
            buf_addr[0] <= '0;
            buf_addr[1] <= '0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            err_type_q  <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                buf_addr[wr_ptr] <= wr_addr;
                buf_data[wr_ptr] <= enc_word;
                wr_ptr           <= ~wr_ptr;
                acc_cnt          <= acc_cnt + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);

            case (state)
                IDLE, DONE: begin
                    if (Start) begin
                        state      <= RUN;
                        base_q     <= Base_Addr;
                        acc_cnt    <= '0;
                        err_type_q <= 1'b0;
                        err_ovf_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && is_rsvd) begin
                        err_type_q <= 1'b1;
                    end
                    // In_Last wins over the depth limit: a program that exactly fills DEPTH is not an overflow.
                    if (accept && In_Last) begin
                        state <= DRAIN;
                    end else if (push && (acc_cnt == CNT_W'(DEPTH - 1))) begin
                        state     <= DRAIN;
                        err_ovf_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if ((count == 2'd0) || ((count == 2'd1) && pop)) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// bundles scored against a field-packing reference model.
module tb_instr_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  t;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        last;
    } bundle_t;

    logic        rst;
    logic        start, in_valid, in_last, imem_ready;
    logic [7:0]  base_addr;
    logic [1:0]  type_in;
    logic [5:0]  opcode_in, funct_in;
    logic [4:0]  rs_in, rt_in, rd_in, shamt_in;
    logic [15:0] imm_in;
    logic [25:0] target_in;
    logic        in_ready, imem_wren, busy, done, err_type, err_ovf;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wrdata;
    logic [1:0]  dbg_state;

    logic        s_start, s_in_valid, s_imem_ready;
    logic [3:0]  s_base_addr;
    logic        s_in_ready, s_wren, s_busy, s_done, s_err_type, s_err_ovf;
    logic [3:0]  s_addr;
    logic [31:0] s_wrdata;
    logic [1:0]  s_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [39:0] exp_q[$];
    logic [39:0] obs_q[$];
    int          obs_cyc[$];
    logic [35:0] s_exp_q[$];
    logic [35:0] s_obs_q[$];

    instr_encoder #(.ADDR_W(8), .DEPTH(256)) u_dut (
        .CLK(clk), .RST(rst), .Start(start), .Base_Addr(base_addr),
        .In_Valid(in_valid), .In_Ready(in_ready), .In_Last(in_last),
        .Type_In(type_in), .OpCode_In(opcode_in), .Funct_In(funct_in),
        .Rs_In(rs_in), .Rt_In(rt_in), .Rd_In(rd_in), .Shamt_In(shamt_in),
        .Imm_In(imm_in), .Target_In(target_in),
        .IMem_WrEn(imem_wren), .IMem_Ready(imem_ready), .IMem_Addr(imem_addr),
        .IMem_WrData(imem_wrdata), .Busy(busy), .Done(done),
        .Err_Type(err_type), .Err_Ovf(err_ovf), .Dbg_State(dbg_state)
    );

    instr_encoder #(.ADDR_W(4), .DEPTH(4)) u_small (
        .CLK(clk), .RST(rst), .Start(s_start), .Base_Addr(s_base_addr),
        .In_Valid(s_in_valid), .In_Ready(s_in_ready), .In_Last(in_last),
        .Type_In(type_in), .OpCode_In(opcode_in), .Funct_In(funct_in),
        .Rs_In(rs_in), .Rt_In(rt_in), .Rd_In(rd_in), .Shamt_In(shamt_in),
        .Imm_In(imm_in), .Target_In(target_in),
        .IMem_WrEn(s_wren), .IMem_Ready(s_imem_ready), .IMem_Addr(s_addr),
        .IMem_WrData(s_wrdata), .Busy(s_busy), .Done(s_done),
        .Err_Type(s_err_type), .Err_Ovf(s_err_ovf), .Dbg_State(s_state)
    );

    // Write monitor: a write completes at the posedge following this negedge.
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (imem_wren && imem_ready) begin
            obs_q.push_back({imem_addr, imem_wrdata});
            obs_cyc.push_back(cyc);
        end
        if (s_wren && s_imem_ready) s_obs_q.push_back({s_addr, s_wrdata});
    end

    // Reference model: MIPS field packing by shift-and-or arithmetic.
    function automatic logic [31:0] model_word(input bundle_t b);
        logic [31:0] w;
        w = 32'd0;
        if (b.t == 2'd0)
            w = (32'(b.rs) << 21) | (32'(b.rt) << 16) | (32'(b.rd) << 11) | (32'(b.sh) << 6) | 32'(b.fn);
        else if (b.t == 2'd1)
            w = (32'(b.op) << 26) | (32'(b.rs) << 21) | (32'(b.rt) << 16) | 32'(b.imm);
        else if (b.t == 2'd2)
            w = (32'(b.op) << 26) | 32'(b.tgt);
        return w;
    endfunction

    function automatic bundle_t rand_bundle(input int tmax);
        bundle_t b;
        b.t = 2'($urandom_range(0, tmax));
        b.op = 6'($urandom); b.fn = 6'($urandom);
        b.rs = 5'($urandom); b.rt = 5'($urandom); b.rd = 5'($urandom); b.sh = 5'($urandom);
        b.imm = 16'($urandom); b.tgt = 26'($urandom);
        b.last = 1'b0;
        return b;
    endfunction

    function automatic bundle_t mk_r(input int rs, input int rt, input int rd, input int fn, input bit last);
        bundle_t b;
        b = rand_bundle(0);
        b.rs = 5'(rs); b.rt = 5'(rt); b.rd = 5'(rd); b.sh = 5'd0; b.fn = 6'(fn); b.last = last;
        return b;
    endfunction

    task automatic set_fields(input bundle_t b);
        type_in = b.t; opcode_in = b.op; funct_in = b.fn;
        rs_in = b.rs; rt_in = b.rt; rd_in = b.rd; shamt_in = b.sh;
        imm_in = b.imm; target_in = b.tgt; in_last = b.last;
    endtask

    // All driver tasks begin and end 1 time unit after a rising edge.
    task automatic drive(input bundle_t b, input int budget, output bit ok);
        set_fields(b);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drive_small(input bundle_t b, input int budget, output bit ok);
        set_fields(b);
        s_in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (s_in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] b);
        base_addr = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (done) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (imem_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren: got %b want 0", imem_wren); end
        n_cmp++; if (imem_addr !== 8'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
        n_cmp++; if (imem_wrdata !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", imem_wrdata); end
        n_cmp++; if ({busy, done, err_type, err_ovf} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err_type, err_ovf}); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        n_cmp++; if ({s_wren, s_busy, s_done, s_err_ovf} !== 4'b0) begin n_bad++; $display("FAIL reset_small: got %b want 0000", {s_wren, s_busy, s_done, s_err_ovf}); end
    endtask

    task automatic test_rtype();
        bit ok;
        obs_q.delete();
        pulse_start(8'h10);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rtype_ready_after_start: got %b want 1", in_ready); end
        drive(mk_r(8, 9, 10, 6'h20, 1'b1), 20, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rtype_accept: got timeout want accept"); end
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rtype_done: got timeout want done"); end
        n_cmp++; if (obs_q.size() !== 1) begin n_bad++; $display("FAIL rtype_count: got %0d want 1", obs_q.size()); end
        n_cmp++; if (obs_q.size() > 0 && obs_q[0] !== {8'h10, 32'h01095020}) begin n_bad++; $display("FAIL rtype_word: got %h want 1001095020", obs_q[0]); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rtype_busy: got %b want 0", busy); end
    endtask

    task automatic test_i_j();
        bit ok;
        bundle_t b;
        obs_q.delete();
        imem_ready = 1'b1;
        pulse_start(8'h40);
        b = rand_bundle(0); b.t = 2'd1; b.op = 6'h23; b.rs = 5'd29; b.rt = 5'd8; b.imm = 16'h0004; b.last = 1'b0;
        drive(b, 20, ok);
        n_cmp++; if (imem_wren !== 1'b1 || imem_addr !== 8'h40) begin n_bad++; $display("FAIL ij_latency: got wren=%b addr=%h want wren=1 addr=40", imem_wren, imem_addr); end
        b = rand_bundle(0); b.t = 2'd2; b.op = 6'h02; b.tgt = 26'h0000010; b.last = 1'b1;
        drive(b, 20, ok);
        wait_done(ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL ij_done: got timeout want done"); end
        n_cmp++; if (obs_q.size() !== 2) begin n_bad++; $display("FAIL ij_count: got %0d want 2", obs_q.size()); end
        n_cmp++; if (obs_q.size() > 1 && (obs_q[0] !== {8'h40, 32'h8FA80004} || obs_q[1] !== {8'h41, 32'h08000010}))
            begin n_bad++; $display("FAIL ij_words: got %h %h want 408FA80004 4108000010", obs_q[0], obs_q[1]); end
    endtask

    task automatic test_random();
        bit ok, sending, all_ok;
        bundle_t b;
        logic [7:0] base;
        int k;
        obs_q.delete(); exp_q.delete();
        base = 8'($urandom_range(200, 255));
        pulse_start(base);
        k = 0; all_ok = 1'b1; sending = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    b = rand_bundle(2);
                    b.last = (i == 23);
                    exp_q.push_back({8'((int'(base) + k) % 256), model_word(b)});
                    k++;
                    drive(b, 60, ok);
                    if (!ok) all_ok = 1'b0;
                end
                sending = 1'b0;
            end
            begin
                while (sending) begin
                    @(posedge clk); #1;
                    imem_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        imem_ready = 1'b1;
        n_cmp++; if (!all_ok) begin n_bad++; $display("FAIL rand_accept: got timeout want all accepted"); end
        wait_done(ok);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit ok, held_ok;
        bundle_t b[3];
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        imem_ready = 1'b0;
        pulse_start(8'h80);
        for (int i = 0; i < 3; i++) begin
            b[i] = rand_bundle(2);
            b[i].last = (i == 2);
            exp_q.push_back({8'(8'h80 + i), model_word(b[i])});
        end
        drive(b[0], 10, ok);
        drive(b[1], 10, ok);
        set_fields(b[2]); in_valid = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || imem_wren !== 1'b1 || {imem_addr, imem_wrdata} !== exp_q[0]) held_ok = 1'b0;
            @(posedge clk); #1;
        end
        n_cmp++; if (!held_ok) begin n_bad++; $display("FAIL bp_hold: got ready=%b wren=%b word=%h want 0 1 %h", in_ready, imem_wren, {imem_addr, imem_wrdata}, exp_q[0]); end
        imem_ready = 1'b1;
        drive(b[2], 10, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_third_accept: got timeout want accept"); end
        wait_done(ok);
        n_cmp++; if (obs_q.size() !== 3) begin n_bad++; $display("FAIL bp_count: got %0d want 3", obs_q.size()); end
        for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_word[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        n_cmp++; if (obs_q.size() === 3 && (obs_cyc[1] !== obs_cyc[0] + 1 || obs_cyc[2] !== obs_cyc[1] + 1))
            begin n_bad++; $display("FAIL bp_consecutive: got cycles %0d %0d %0d want consecutive", obs_cyc[0], obs_cyc[1], obs_cyc[2]); end
    endtask

    task automatic test_reserved();
        bit ok;
        bundle_t r;
        logic [7:0] base;
        obs_q.delete();
        base = 8'($urandom_range(0, 254));
        pulse_start(base);
        drive(mk_r(1, 2, 3, 6'h20, 1'b0), 20, ok);
        r = rand_bundle(0); r.t = 2'b11; r.last = 1'b0;
        drive(r, 20, ok);
        drive(mk_r(4, 5, 6, 6'h22, 1'b1), 20, ok);
        wait_done(ok);
        n_cmp++; if (obs_q.size() !== 2) begin n_bad++; $display("FAIL rsvd_count: got %0d want 2", obs_q.size()); end
        n_cmp++; if (obs_q.size() > 1 && (obs_q[0][39:32] !== base || obs_q[1][39:32] !== 8'(base + 1)))
            begin n_bad++; $display("FAIL rsvd_addr: got %h %h want %h %h", obs_q[0][39:32], obs_q[1][39:32], base, 8'(base + 1)); end
        n_cmp++; if (err_type !== 1'b1) begin n_bad++; $display("FAIL rsvd_err: got %b want 1", err_type); end
        obs_q.delete();
        pulse_start(8'h20);
        n_cmp++; if (err_type !== 1'b0) begin n_bad++; $display("FAIL rsvd_clear: got %b want 0", err_type); end
        drive(mk_r(7, 7, 7, 6'h25, 1'b0), 20, ok);
        r.last = 1'b1;
        drive(r, 20, ok);
        wait_done(ok);
        n_cmp++; if (!ok || obs_q.size() !== 1) begin n_bad++; $display("FAIL rsvd_last_ends: got done=%b writes=%0d want 1 1", done, obs_q.size()); end
        n_cmp++; if (err_type !== 1'b1) begin n_bad++; $display("FAIL rsvd_last_err: got %b want 1", err_type); end
    endtask

    task automatic test_rst_mid();
        bit ok;
        obs_q.delete();
        imem_ready = 1'b0;
        pulse_start(8'h30);
        drive(mk_r(1, 1, 1, 6'h20, 1'b0), 10, ok);
        drive(mk_r(2, 2, 2, 6'h20, 1'b0), 10, ok);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_full: got in_ready %b want 0", in_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (imem_wren !== 1'b0 || dbg_state !== 2'd0 || busy !== 1'b0)
            begin n_bad++; $display("FAIL rst_mid: got wren=%b state=%0d busy=%b want 0 0 0", imem_wren, dbg_state, busy); end
        imem_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (obs_q.size() !== 0) begin n_bad++; $display("FAIL rst_no_writes: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_start_ignored();
        bit ok;
        obs_q.delete();
        pulse_start(8'h50);
        drive(mk_r(3, 3, 3, 6'h20, 1'b0), 20, ok);
        pulse_start(8'hA0);
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL ign_busy: got busy=%b done=%b want 1 0", busy, done); end
        drive(mk_r(4, 4, 4, 6'h20, 1'b1), 20, ok);
        wait_done(ok);
        n_cmp++; if (obs_q.size() !== 2 || obs_q[0][39:32] !== 8'h50 || obs_q[1][39:32] !== 8'h51)
            begin n_bad++; $display("FAIL ign_addr: got n=%0d first=%h want 2 50 51", obs_q.size(), obs_q.size() > 0 ? obs_q[0][39:32] : 8'h0); end
    endtask

    task automatic test_wrap_ovf();
        bit ok;
        bundle_t b;
        s_obs_q.delete(); s_exp_q.delete();
        s_imem_ready = 1'b1;
        s_base_addr = 4'hE; s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = rand_bundle(2);
            if (i < 4) s_exp_q.push_back({4'((14 + i) % 16), model_word(b)});
            drive_small(b, 10, ok);
            if (i == 4) begin
                n_cmp++; if (ok) begin n_bad++; $display("FAIL ovf_fifth: got accepted want refused"); end
            end
        end
        n_cmp++; if (s_obs_q.size() !== 4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", s_obs_q.size()); end
        for (int i = 0; i < 4 && i < s_obs_q.size(); i++) begin
            n_cmp++;
            if (s_obs_q[i] !== s_exp_q[i]) begin n_bad++; $display("FAIL ovf_word[%0d]: got %h want %h", i, s_obs_q[i], s_exp_q[i]); end
        end
        n_cmp++; if (s_err_ovf !== 1'b1 || s_done !== 1'b1 || s_state !== 2'd3)
            begin n_bad++; $display("FAIL ovf_end: got ovf=%b done=%b state=%0d want 1 1 3", s_err_ovf, s_done, s_state); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_ready = 1'b1; base_addr = '0;
        s_start = 1'b0; s_in_valid = 1'b0; s_imem_ready = 1'b1; s_base_addr = '0;
        type_in = '0; opcode_in = '0; funct_in = '0; rs_in = '0; rt_in = '0; rd_in = '0;
        shamt_in = '0; imm_in = '0; target_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_rtype();
        test_i_j();
        test_random();
        test_backpressure();
        test_reserved();
        test_rst_mid();
        test_start_ignored();
        test_wrap_ovf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
